// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-gated PHY/MAC/user reset sequencer with ack timeout and restart counter
// Moore outputs are registered from the next-state decode so they change on the same edge as the state.
module reset_sequencer #(
   parameter int PHY_RST_CYCLES = 16,
   parameter int SETTLE_CYCLES  = 32,
   parameter int ACK_TIMEOUT    = 64,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       ext_reset,
   input  logic       mac_ready,
   output logic       phy_rst_n,
   output logic       mac_rst,
   output logic       user_rst,
   output logic       ready,
   output logic       fault,
   output logic [7:0] restart_count
);

   typedef enum logic [2:0] {
      S_LOCK     = 3'd0,
      S_PHY_RST  = 3'd1,
      S_SETTLE   = 3'd2,
      S_MAC_WAIT = 3'd3,
      S_RUN      = 3'd4,
      S_FAULT    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pll_lock_m;
   logic             pll_lock_s;
   logic             ext_reset_m;
   logic             ext_reset_s;
   logic             restart_req;
   logic             restart_inc;
   logic             phy_rst_n_nxt;
   logic             mac_rst_nxt;
   logic             user_rst_nxt;
   logic             ready_nxt;
   logic             fault_nxt;
   logic [7:0]       restart_count_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pll_lock_m  <= 1'b0;
         pll_lock_s  <= 1'b0;
         ext_reset_m <= 1'b0;
         ext_reset_s <= 1'b0;
      end else begin
         pll_lock_m  <= pll_lock;
         pll_lock_s  <= pll_lock_m;
         ext_reset_m <= ext_reset;
         ext_reset_s <= ext_reset_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_LOCK;
         cnt           <= '0;
         phy_rst_n     <= 1'b0;
         mac_rst       <= 1'b1;
         user_rst      <= 1'b1;
         ready         <= 1'b0;
         fault         <= 1'b0;
         restart_count <= 8'd0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         phy_rst_n     <= phy_rst_n_nxt;
         mac_rst       <= mac_rst_nxt;
         user_rst      <= user_rst_nxt;
         ready         <= ready_nxt;
         fault         <= fault_nxt;
         restart_count <= restart_count_nxt;
      end
   end

   assign restart_req = !pll_lock_s || ext_reset_s;

   // Lost lock or an external request outranks every sequencing transition.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      restart_inc = 1'b0;
      if (state != S_LOCK && state != S_FAULT && restart_req) begin
         state_nxt   = S_LOCK;
         cnt_nxt     = '0;
         restart_inc = 1'b1;
      end else begin
         unique case (state)
            S_LOCK: begin
               if (pll_lock_s && !ext_reset_s) begin
                  state_nxt = S_PHY_RST;
                  cnt_nxt   = '0;
               end
            end
            S_PHY_RST: begin
               if (cnt == PHY_LAST) begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state_nxt = S_MAC_WAIT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            S_MAC_WAIT: begin
               if (mac_ready) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
               end else if (cnt == ACK_LAST) begin
                  state_nxt = S_FAULT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               state_nxt = S_RUN;
            end
            S_FAULT: begin
               if (ext_reset_s) begin
                  state_nxt = S_LOCK;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               state_nxt = S_LOCK;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      phy_rst_n_nxt = 1'b0;
      mac_rst_nxt   = 1'b1;
      user_rst_nxt  = 1'b1;
      ready_nxt     = 1'b0;
      fault_nxt     = 1'b0;
      unique case (state_nxt)
         S_LOCK, S_PHY_RST: begin
            phy_rst_n_nxt = 1'b0;
         end
         S_SETTLE: begin
            phy_rst_n_nxt = 1'b1;
         end
         S_MAC_WAIT: begin
            phy_rst_n_nxt = 1'b1;
            mac_rst_nxt   = 1'b0;
         end
         S_RUN: begin
            phy_rst_n_nxt = 1'b1;
            mac_rst_nxt   = 1'b0;
            user_rst_nxt  = 1'b0;
            ready_nxt     = 1'b1;
         end
         S_FAULT: begin
            fault_nxt = 1'b1;
         end
         default: begin
            phy_rst_n_nxt = 1'b0;
         end
      endcase
   end

   assign restart_count_nxt = (restart_inc && restart_count != 8'hFF) ?
                              restart_count + 8'd1 : restart_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer against a phase/position model
module tb_reset_sequencer;

   localparam int PHY = 4;
   localparam int SET = 8;
   localparam int ACK = 16;
   localparam int LIM = 200;

   localparam int M_LOCK  = 0;
   localparam int M_SEQ   = 1;
   localparam int M_RUN   = 2;
   localparam int M_FAULT = 3;

   logic       clk;
   logic       rst;
   logic       pll_lock;
   logic       ext_reset;
   logic       mac_ready;
   logic       phy_rst_n;
   logic       mac_rst;
   logic       user_rst;
   logic       ready;
   logic       fault;
   logic [7:0] restart_count;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .PHY_RST_CYCLES(PHY),
      .SETTLE_CYCLES (SET),
      .ACK_TIMEOUT   (ACK),
      .CNT_W         (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_lock     (pll_lock),
      .ext_reset    (ext_reset),
      .mac_ready    (mac_ready),
      .phy_rst_n    (phy_rst_n),
      .mac_rst      (mac_rst),
      .user_rst     (user_rst),
      .ready        (ready),
      .fault        (fault),
      .restart_count(restart_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode plus position since sequence start; sub-phase follows from pos ranges.
   typedef struct {
      int mode;
      int pos;
      int rc;
   } mstate_t;

   mstate_t m;
   bit m_p1, m_p2, m_e1, m_e2;

   function automatic mstate_t step(input mstate_t s, input bit p, input bit e, input bit mr);
      mstate_t n;
      bit      restart;
      n = s;
      restart = !p || e;
      case (s.mode)
         M_LOCK: if (p && !e) begin
            n.mode = M_SEQ;
            n.pos  = 0;
         end
         M_SEQ: begin
            if (restart) begin
               n.mode = M_LOCK;
               n.rc   = (s.rc < 255) ? s.rc + 1 : 255;
            end else if (s.pos < PHY + SET) begin
               n.pos = s.pos + 1;
            end else if (mr) begin
               n.mode = M_RUN;
            end else if (s.pos - (PHY + SET) == ACK - 1) begin
               n.mode = M_FAULT;
            end else begin
               n.pos = s.pos + 1;
            end
         end
         M_RUN: if (restart) begin
            n.mode = M_LOCK;
            n.rc   = (s.rc < 255) ? s.rc + 1 : 255;
         end
         default: if (e) n.mode = M_LOCK;
      endcase
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m    <= '{M_LOCK, 0, 0};
         m_p1 <= 1'b0;
         m_p2 <= 1'b0;
         m_e1 <= 1'b0;
         m_e2 <= 1'b0;
      end else begin
         m    <= step(m, m_p2, m_e2, mac_ready);
         m_p1 <= pll_lock;
         m_p2 <= m_p1;
         m_e1 <= ext_reset;
         m_e2 <= m_e1;
      end
   end

   always @(negedge clk) begin
      bit in_seq, past_phy, past_set;
      in_seq   = (m.mode == M_SEQ);
      past_phy = in_seq && m.pos >= PHY;
      past_set = in_seq && m.pos >= PHY + SET;
      chk("cyc_phy_rst_n", phy_rst_n, (past_phy || m.mode == M_RUN) ? 1 : 0);
      chk("cyc_mac_rst", mac_rst, (past_set || m.mode == M_RUN) ? 0 : 1);
      chk("cyc_user_rst", user_rst, (m.mode == M_RUN) ? 0 : 1);
      chk("cyc_ready", ready, (m.mode == M_RUN) ? 1 : 0);
      chk("cyc_fault", fault, (m.mode == M_FAULT) ? 1 : 0);
      chk("cyc_restart_count", restart_count, m.rc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  n;
      bit  mac_dropped;
      rst       = 1'b1;
      pll_lock  = 1'b0;
      ext_reset = 1'b0;
      mac_ready = 1'b1;
      repeat (3) tick();
      chk("rst_phy_rst_n", phy_rst_n, 0);
      chk("rst_mac_rst", mac_rst, 1);
      chk("rst_user_rst", user_rst, 1);
      chk("rst_ready", ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_restart_count", restart_count, 0);

      // Power-up: two sync edges, one edge into PHY reset, four low cycles.
      pll_lock = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (!phy_rst_n && n < LIM) begin tick(); n++; end
      chk("pwr_phy_rise_edges", n, 7);
      n = 0;
      while (mac_rst && n < LIM) begin tick(); n++; end
      chk("pwr_mac_fall_gap", n, 8);
      n = 0;
      while (!ready && n < LIM) begin tick(); n++; end
      chk("pwr_ready_gap", n, 1);
      chk("pwr_user_rst", user_rst, 0);
      chk("pwr_restart_count", restart_count, 0);

      // ext_reset held for three cycles while running.
      ext_reset = 1'b1;
      n = 0;
      while (ready && n < LIM) begin
         tick();
         n++;
         if (n == 3) ext_reset = 1'b0;
      end
      ext_reset = 1'b0;
      chk("ext_ready_fall_edges", n, 3);
      chk("ext_phy_rst_n", phy_rst_n, 0);
      chk("ext_mac_rst", mac_rst, 1);
      chk("ext_user_rst", user_rst, 1);
      chk("ext_restart_count", restart_count, 1);

      // Withhold the ack so the sequence times out.
      mac_ready = 1'b0;
      n = 0;
      while (mac_rst && n < LIM) begin tick(); n++; end
      chk("to_mac_wait_reached", (n < LIM) ? 1 : 0, 1);
      n = 0;
      while (!fault && n < LIM) begin tick(); n++; end
      chk("to_fault_edges", n, 16);
      chk("to_phy_rst_n", phy_rst_n, 0);
      chk("to_mac_rst", mac_rst, 1);
      for (int i = 0; i < 6; i++) begin
         pll_lock = ~pll_lock;
         tick();
      end
      pll_lock = 1'b1;
      repeat (4) tick();
      chk("to_fault_sticky", fault, 1);
      ext_reset = 1'b1;
      tick();
      ext_reset = 1'b0;
      n = 0;
      while (fault && n < LIM) begin tick(); n++; end
      chk("to_exit_edges", n, 2);
      chk("to_exit_restart_count", restart_count, 1);

      // Ack arrives exactly on the last wait cycle.
      n = 0;
      while (mac_rst && n < LIM) begin tick(); n++; end
      chk("late_mac_wait_reached", (n < LIM) ? 1 : 0, 1);
      repeat (15) tick();
      mac_ready = 1'b1;
      tick();
      chk("late_ready", ready, 1);
      chk("late_fault", fault, 0);

      // Lock loss during settle, after a one-cycle ext pulse restart.
      ext_reset = 1'b1;
      tick();
      ext_reset = 1'b0;
      n = 0;
      while (ready && n < LIM) begin tick(); n++; end
      n = 0;
      while (!phy_rst_n && n < LIM) begin tick(); n++; end
      chk("pll_settle_reached", (n < LIM) ? 1 : 0, 1);
      tick();
      pll_lock = 1'b0;
      repeat (2) tick();
      pll_lock = 1'b1;
      n = 0;
      mac_dropped = 1'b0;
      while ((n < 3 || !phy_rst_n) && n < LIM) begin
         tick();
         n++;
         if (!mac_rst) mac_dropped = 1'b1;
      end
      chk("pll_phy_rise_edges", n, 7);
      chk("pll_mac_held", mac_dropped, 0);
      chk("pll_restart_count", restart_count, 3);
      n = 0;
      while (!ready && n < LIM) begin tick(); n++; end
      chk("pll_ready_again", ready, 1);

      // Asynchronous reset mid-cycle.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_phy_rst_n", phy_rst_n, 0);
      chk("arst_mac_rst", mac_rst, 1);
      chk("arst_user_rst", user_rst, 1);
      chk("arst_ready", ready, 0);
      chk("arst_restart_count", restart_count, 0);
      repeat (3) tick();
      rst = 1'b0;
      n = 0;
      while (!ready && n < LIM) begin tick(); n++; end
      chk("arst_resume_ready", ready, 1);

      // Restart counter saturation.
      for (int i = 0; i < 300; i++) begin
         ext_reset = 1'b1;
         tick();
         ext_reset = 1'b0;
         repeat (4) tick();
      end
      chk("sat_restart_count", restart_count, 255);
      n = 0;
      while (!ready && n < LIM) begin tick(); n++; end
      chk("sat_ready_again", ready, 1);
      chk("sat_restart_hold", restart_count, 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
